// File: rtl/booth_ctrl.sv
// booth_ctrl: sequencing controller for the radix-4 Booth multiplier datapath.
// It takes an 8x8 signed operand pair over a valid/ready handshake, drives the
// datapath operand bus and its ld/sel controls through four add/shift
// iterations, captures the 16-bit product and hands it out over a second
// valid/ready handshake. The datapath shares rst with this block.

module booth_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  mcand,
  input  logic [7:0]  mplier,
  output logic [4:0]  ld,
  output logic [4:0]  sel,
  output logic [7:0]  inputnum,
  input  logic        eqz,
  input  logic [15:0] result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] product
);

  // Encodings are fixed so that the datapath and debug tools agree on them;
  // the unused code 3'b111 falls back to IDLE through the case default.
  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    LDA   = 3'b001,
    LDB   = 3'b010,
    ADD   = 3'b011,
    SHIFT = 3'b100,
    CAP   = 3'b101,
    DONE  = 3'b110
  } state_t;

  // Datapath control words, written as {ld4..ld0} / {sel4..sel0}.
  localparam logic [4:0] LD_LDA    = 5'b10111;
  localparam logic [4:0] LD_LDB    = 5'b01000;
  localparam logic [4:0] LD_ADD    = 5'b00101;
  localparam logic [4:0] SEL_ADD   = 5'b00101;
  localparam logic [4:0] LD_SHIFT  = 5'b11100;
  localparam logic [4:0] SEL_SHIFT = 5'b11110;

  state_t      state;
  state_t      state_next;
  logic [7:0]  mcand_q;
  logic [7:0]  mplier_q;
  logic        accept;

  // A pair is taken only while idle; reset has priority over acceptance.
  assign accept = in_valid && in_ready;

  // State register with synchronous reset back to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Holding registers keep the accepted operands while the bus walks them in.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= 8'h00;
      mplier_q <= 8'h00;
    end else if (accept) begin
      mcand_q  <= mcand;
      mplier_q <= mplier;
    end
  end

  // Product register grabs the datapath result once the last shift settles.
  always_ff @(posedge clk) begin
    if (rst) begin
      product <= 16'h0000;
    end else if (state == CAP) begin
      product <= result;
    end
  end

  // Next-state logic and all state-decoded outputs to the datapath.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    ld         = 5'b00000;
    sel        = 5'b00000;
    inputnum   = 8'h00;

    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = LDA;
        end
      end

      LDA: begin
        // Load multiplicand, preset count to 4, clear acc and last bit.
        inputnum   = mcand_q;
        ld         = LD_LDA;
        state_next = LDB;
      end

      LDB: begin
        // Load multiplier from the bus; the complement register follows.
        inputnum   = mplier_q;
        ld         = LD_LDB;
        state_next = ADD;
      end

      ADD: begin
        // acc += Booth term, count decrements on the same edge.
        ld         = LD_ADD;
        sel        = SEL_ADD;
        state_next = SHIFT;
      end

      SHIFT: begin
        // Arithmetic shift of {acc, mplier, last} by two; eqz already sees
        // the decremented count, so it decides whether another pass runs.
        ld  = LD_SHIFT;
        sel = SEL_SHIFT;
        if (eqz) begin
          state_next = CAP;
        end else begin
          state_next = ADD;
        end
      end

      CAP: begin
        state_next = DONE;
      end

      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
